// File: rtl/vx_prefetch_throttle_if.sv
// Eviction-metadata / prefetch-control bundle between a bank's metadata store and its throttle.
// PREFETCH_THROTTLE_PERF_EN adds the performance-counter outputs.
interface vx_prefetch_throttle_if;
    logic        evict_valid;
    logic        evict_prefetched;
    logic        evict_used;
    logic        pf_enable;
    logic [2:0]  pf_degree;
    logic        epoch_done;
`ifdef PREFETCH_THROTTLE_PERF_EN
    logic [31:0] perf_pf_evicts;
    logic [31:0] perf_pf_useful;
    logic [15:0] perf_state_changes;

    modport master (
        output evict_valid, evict_prefetched, evict_used,
        input  pf_enable, pf_degree, epoch_done,
        input  perf_pf_evicts, perf_pf_useful, perf_state_changes
    );

    modport slave (
        input  evict_valid, evict_prefetched, evict_used,
        output pf_enable, pf_degree, epoch_done,
        output perf_pf_evicts, perf_pf_useful, perf_state_changes
    );
`else
    modport master (
        output evict_valid, evict_prefetched, evict_used,
        input  pf_enable, pf_degree, epoch_done
    );

    modport slave (
        input  evict_valid, evict_prefetched, evict_used,
        output pf_enable, pf_degree, epoch_done
    );
`endif
endinterface

// File: rtl/vx_prefetch_throttle.sv
// Per-bank prefetch throttle: epoch-based accuracy measurement driving a 4-level degree FSM.
// Define PREFETCH_THROTTLE_PERF_EN to add the perf counters on the interface.
module vx_prefetch_throttle #(
    parameter int CACHE_ID   = 0,
    parameter int BANK_ID    = 0,
    parameter int EPOCH_SIZE = 64,
    parameter int HI_THRESH  = 6,
    parameter int LO_THRESH  = 2,
    parameter int OFF_HOLD   = 1024
) (
    input logic                   clk,
    input logic                   reset,
    vx_prefetch_throttle_if.slave bus
);

    localparam int CW = $clog2(EPOCH_SIZE) + 1;
    localparam int PW = $clog2(EPOCH_SIZE) + 4;
    localparam int HW = (OFF_HOLD > 1) ? $clog2(OFF_HOLD) : 1;

    localparam logic [CW-1:0] EPOCH_FULL = CW'(EPOCH_SIZE);
    localparam logic [PW-1:0] HI_PROD    = PW'(HI_THRESH * EPOCH_SIZE);
    localparam logic [PW-1:0] LO_PROD    = PW'(LO_THRESH * EPOCH_SIZE);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(OFF_HOLD - 1);

    if (EPOCH_SIZE < 4 || (EPOCH_SIZE & (EPOCH_SIZE - 1)) != 0) begin : g_bad_epoch
        $error("EPOCH_SIZE must be a power of 2 and at least 4");
    end
    if (HI_THRESH > 8 || LO_THRESH > 8 || HI_THRESH <= LO_THRESH) begin : g_bad_thresh
        $error("thresholds must satisfy LO_THRESH < HI_THRESH <= 8");
    end
    if (OFF_HOLD < 1 || CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_misc
        $error("OFF_HOLD must be >= 1 and ids non-negative");
    end

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    state_t        state_reg,      state_next;
    logic [CW-1:0] pf_cnt_reg,     pf_cnt_next;
    logic [CW-1:0] use_cnt_reg,    use_cnt_next;
    logic [HW-1:0] hold_cnt_reg,   hold_cnt_next;
    logic          epoch_done_reg, epoch_done_next;
    logic          pf_enable_reg;
    logic [2:0]    pf_degree_reg;

    logic          sample;
    logic [CW-1:0] pf_inc;
    logic [CW-1:0] use_inc;
    logic [PW-1:0] use_prod;
    logic          up;
    logic          down;

    // Degree per state encoding: OFF=0, LOW=1, MID=2, HIGH=4.
    logic [2:0] deg_lut [4];
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_deg_lut
        assign deg_lut[gi] = 3'((4'd1 << gi) >> 1);
    end

    assign sample   = bus.evict_valid && bus.evict_prefetched;
    assign pf_inc   = pf_cnt_reg + CW'(1);
    assign use_inc  = use_cnt_reg + CW'(bus.evict_used);
    // Accuracy compared in eighths by scaling the used count instead of dividing.
    assign use_prod = {use_inc, 3'b000};
    assign up       = (use_prod >= HI_PROD);
    assign down     = (use_prod <  LO_PROD);

    always_comb begin
        state_next      = state_reg;
        pf_cnt_next     = pf_cnt_reg;
        use_cnt_next    = use_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        epoch_done_next = 1'b0;

        if (state_reg == ST_OFF) begin
            // Late prefetched evictions are dropped here; only time advances the hold.
            if (hold_cnt_reg == HOLD_LAST) begin
                state_next    = ST_LOW;
                hold_cnt_next = '0;
            end else begin
                hold_cnt_next = hold_cnt_reg + HW'(1);
            end
        end else if (sample) begin
            if (pf_inc == EPOCH_FULL) begin
                epoch_done_next = 1'b1;
                pf_cnt_next     = '0;
                use_cnt_next    = '0;
                unique case (state_reg)
                    ST_LOW: begin
                        if (up)        state_next = ST_MID;
                        else if (down) state_next = ST_OFF;
                    end
                    ST_MID: begin
                        if (up)        state_next = ST_HIGH;
                        else if (down) state_next = ST_LOW;
                    end
                    ST_HIGH: begin
                        if (down)      state_next = ST_MID;
                    end
                    default: state_next = state_reg;
                endcase
            end else begin
                pf_cnt_next  = pf_inc;
                use_cnt_next = use_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_LOW;
            pf_cnt_reg     <= '0;
            use_cnt_reg    <= '0;
            hold_cnt_reg   <= '0;
            epoch_done_reg <= 1'b0;
            pf_enable_reg  <= 1'b1;
            pf_degree_reg  <= 3'd1;
        end else begin
            state_reg      <= state_next;
            pf_cnt_reg     <= pf_cnt_next;
            use_cnt_reg    <= use_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            epoch_done_reg <= epoch_done_next;
            pf_enable_reg  <= (state_next != ST_OFF);
            pf_degree_reg  <= deg_lut[state_next];
        end
    end

    assign bus.pf_enable  = pf_enable_reg;
    assign bus.pf_degree  = pf_degree_reg;
    assign bus.epoch_done = epoch_done_reg;

`ifdef PREFETCH_THROTTLE_PERF_EN
    logic [31:0] perf_evicts_reg;
    logic [31:0] perf_useful_reg;
    logic [15:0] perf_changes_reg;
    logic        counted;

    assign counted = sample && (state_reg != ST_OFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_evicts_reg  <= '0;
            perf_useful_reg  <= '0;
            perf_changes_reg <= '0;
        end else begin
            if (counted)
                perf_evicts_reg <= perf_evicts_reg + 32'd1;
            if (counted && bus.evict_used)
                perf_useful_reg <= perf_useful_reg + 32'd1;
            if (state_next != state_reg)
                perf_changes_reg <= perf_changes_reg + 16'd1;
        end
    end

    assign bus.perf_pf_evicts     = perf_evicts_reg;
    assign bus.perf_pf_useful     = perf_useful_reg;
    assign bus.perf_state_changes = perf_changes_reg;
`endif

endmodule
